// File: rtl/mint_vectored.sv
// Vectored interrupt controller: fixed priority (higher index wins), nesting, EPC stack.
// Define MINT_LEVEL_EN for level-sensitive channels; default build captures rising edges.
module mint_vectored #(
  parameter  int          NUM_CH     = 3,
  parameter  int          NEST_DEPTH = 3,
  parameter  logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter  logic [31:0] VEC_STRIDE = 32'h10,
  localparam int          CODE_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              in_RST,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic              ie,
  input  logic [NUM_CH-1:0] mask,
  input  logic              take,
  input  logic              eret,
  input  logic [31:0]       cur_pc,
  output logic              int_req,
  output logic [31:0]       int_vec,
  output logic [CODE_W-1:0] int_code,
  output logic [31:0]       epc,
  output logic [NUM_CH-1:0] busy,
  output logic              nest_err
);

  localparam int              SP_W    = $clog2(NEST_DEPTH + 1);
  localparam int              STK_N   = 1 << SP_W;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(NEST_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d, sel, popped_code;
  logic [NUM_CH-1:0] sync1_q, sync2_q, pending, blocked, eligible;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [SP_W-1:0]   sp_q, sp_d, top_idx, wr_idx;
  logic              nest_err_q, nest_err_d;
  logic              push, pop;
  logic [31:0]       stk_pc_q   [STK_N];
  logic [CODE_W-1:0] stk_code_q [STK_N];

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge in_RST) begin
    if (!in_RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign push = (state_q == REQ) && take;
  assign pop  = eret && (sp_q != '0);

`ifdef MINT_LEVEL_EN
  assign pending = sync2_q;
`else
  logic [NUM_CH-1:0] prev_q, pending_q, pending_d;

  // A new edge arriving in the same cycle as take wins over the clear.
  always_comb begin
    pending_d = pending_q;
    if (push) pending_d[code_q] = 1'b0;
    pending_d = pending_d | (sync2_q & ~prev_q);
  end

  always_ff @(posedge clk or negedge in_RST) begin
    if (!in_RST) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= sync2_q;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
`endif

  // A channel is blocked when it or any higher channel is in service.
  always_comb begin
    sel      = '0;
    blocked  = '0;
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      blocked[i]  = |(busy_q >> i);
      eligible[i] = pending[i] & ~mask[i] & ~blocked[i] & ie & (sp_q < SP_FULL);
      if (eligible[i]) sel = CODE_W'(i);
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = REQ;
          code_d  = sel;
        end
      end
      REQ: begin
        if (take)                   state_d = HOLD;
        else if (!eligible[code_q]) state_d = IDLE;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign top_idx     = sp_q - SP_W'(1);
  assign wr_idx      = pop ? top_idx : sp_q;
  assign popped_code = stk_code_q[top_idx];

  // Pop happens before push, so take+eret together replace the top entry.
  always_comb begin
    busy_d     = busy_q;
    sp_d       = sp_q;
    nest_err_d = nest_err_q | (eret && (sp_q == '0));
    if (pop) begin
      busy_d[popped_code] = 1'b0;
      sp_d                = top_idx;
    end
    if (push) begin
      busy_d[code_q] = 1'b1;
      sp_d           = pop ? sp_q : sp_q + SP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge in_RST) begin
    if (!in_RST) begin
      state_q    <= IDLE;
      code_q     <= '0;
      busy_q     <= '0;
      sp_q       <= '0;
      nest_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      busy_q     <= busy_d;
      sp_q       <= sp_d;
      nest_err_q <= nest_err_d;
    end
  end

  // NOTE: the stack array is not reset; entries at or above sp are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      stk_pc_q[wr_idx]   <= cur_pc;
      stk_code_q[wr_idx] <= code_q;
    end
  end

  assign int_req  = (state_q == REQ);
  assign int_code = code_q;
  assign int_vec  = VEC_BASE + 32'(code_q) * VEC_STRIDE;
  assign epc      = (sp_q == '0) ? 32'h0 : stk_pc_q[top_idx];
  assign busy     = busy_q;
  assign nest_err = nest_err_q;

endmodule

// File: tb/tb_mint_vectored.sv
// Directed bench for mint_vectored (NUM_CH=3, NEST_DEPTH=2, VEC_BASE=0x100, VEC_STRIDE=0x10).
// The MINT_LEVEL_EN build runs the level-sensitive sequence instead of the edge sequence.
module tb_mint_vectored;

  logic        clk = 1'b0;
  logic        in_RST;
  logic [2:0]  irq_in;
  logic        ie;
  logic [2:0]  mask;
  logic        take;
  logic        eret;
  logic [31:0] cur_pc;
  logic        int_req;
  logic [31:0] int_vec;
  logic [1:0]  int_code;
  logic [31:0] epc;
  logic [2:0]  busy;
  logic        nest_err;

  int n_cmp = 0;
  int n_err = 0;

  mint_vectored #(
    .NUM_CH     (3),
    .NEST_DEPTH (2),
    .VEC_BASE   (32'h100),
    .VEC_STRIDE (32'h10)
  ) dut (
    .clk      (clk),
    .in_RST   (in_RST),
    .irq_in   (irq_in),
    .ie       (ie),
    .mask     (mask),
    .take     (take),
    .eret     (eret),
    .cur_pc   (cur_pc),
    .int_req  (int_req),
    .int_vec  (int_vec),
    .int_code (int_code),
    .epc      (epc),
    .busy     (busy),
    .nest_err (nest_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int ch);
    irq_in[ch] = 1'b1;
    tick();
    irq_in[ch] = 1'b0;
  endtask

  task automatic do_take(input logic [31:0] pc);
    cur_pc = pc;
    take   = 1'b1;
    tick();
    take   = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},  32'(int_req),  32'h0);
    check({tag, "_code"}, 32'(int_code), 32'h0);
    check({tag, "_vec"},  int_vec,       32'h100);
    check({tag, "_epc"},  epc,           32'h0);
    check({tag, "_busy"}, 32'(busy),     32'h0);
    check({tag, "_nerr"}, 32'(nest_err), 32'h0);
  endtask

  initial begin
    in_RST = 1'b0;
    irq_in = '0;
    ie     = 1'b1;
    mask   = '0;
    take   = 1'b0;
    eret   = 1'b0;
    cur_pc = '0;
    tick(2);
    check_reset_outputs("rst");
    in_RST = 1'b1;
    tick();

`ifdef MINT_LEVEL_EN
    // Level mode: held request, blocked while in service, re-requested after eret.
    irq_in[0] = 1'b1;
    tick(2);
    check("lvl_early", 32'(int_req), 32'h0);
    tick();
    check("lvl_req",  32'(int_req),  32'h1);
    check("lvl_code", 32'(int_code), 32'h0);
    check("lvl_vec",  int_vec,       32'h100);
    do_take(32'h44);
    check("lvl_take_busy", 32'(busy), 32'h1);
    check("lvl_take_epc",  epc,       32'h44);
    check("lvl_take_req",  32'(int_req), 32'h0);
    tick(4);
    check("lvl_busy_block", 32'(int_req), 32'h0);
    do_eret();
    check("lvl_eret_busy", 32'(busy), 32'h0);
    check("lvl_eret_epc",  epc,       32'h0);
    tick();
    check("lvl_rereq",      32'(int_req),  32'h1);
    check("lvl_rereq_code", 32'(int_code), 32'h0);
`else
    // 1: latency and first take.
    pulse(1);
    tick(2);
    check("t1_early", 32'(int_req), 32'h0);
    tick();
    check("t1_req",  32'(int_req),  32'h1);
    check("t1_code", 32'(int_code), 32'h1);
    check("t1_vec",  int_vec,       32'h110);
    do_take(32'h40);
    check("t1_busy", 32'(busy),    32'h2);
    check("t1_epc",  epc,          32'h40);
    check("t1_gap1", 32'(int_req), 32'h0);
    tick();
    check("t1_gap2", 32'(int_req), 32'h0);

    // 2: lower channel blocked, higher channel preempts, eret restores.
    pulse(0);
    tick(4);
    check("t2_ch0_blocked", 32'(int_req), 32'h0);
    pulse(2);
    tick(3);
    check("t2_req",  32'(int_req),  32'h1);
    check("t2_code", 32'(int_code), 32'h2);
    check("t2_vec",  int_vec,       32'h120);
    do_take(32'h80);
    check("t2_epc",  epc,       32'h80);
    check("t2_busy", 32'(busy), 32'h6);
    tick();
    do_eret();
    check("t2_eret_epc",  epc,       32'h40);
    check("t2_eret_busy", 32'(busy), 32'h2);
    tick(3);
    check("t2_ch0_still", 32'(int_req), 32'h0);

    // 3: queued ch0 served after eret, then stack-full blocking with pending retained.
    do_eret();
    check("t3_eret_busy", 32'(busy),    32'h0);
    check("t3_eret_req",  32'(int_req), 32'h0);
    tick();
    check("t3_ch0_req", 32'(int_req),  32'h1);
    check("t3_ch0_vec", int_vec,       32'h100);
    do_take(32'h10);
    check("t3_ch0_busy", 32'(busy), 32'h1);
    tick();
    pulse(1);
    tick(3);
    check("t3_ch1_code", 32'(int_code), 32'h1);
    do_take(32'h20);
    check("t3_full_busy", 32'(busy), 32'h3);
    check("t3_full_epc",  epc,       32'h20);
    tick();
    pulse(2);
    tick(5);
    check("t3_full_block", 32'(int_req), 32'h0);
    do_eret();
    check("t3_pop_busy", 32'(busy), 32'h1);
    check("t3_pop_epc",  epc,       32'h10);
    tick();
    check("t3_ch2_req",  32'(int_req), 32'h1);
    check("t3_ch2_vec",  int_vec,      32'h120);
    do_take(32'h30);
    check("t3_ch2_busy", 32'(busy), 32'h5);
    check("t3_ch2_epc",  epc,       32'h30);
    tick();
    eret = 1'b1;
    tick();
    check("t3_eret1_epc", epc,       32'h10);
    check("t3_eret1_bsy", 32'(busy), 32'h1);
    tick();
    eret = 1'b0;
    check("t3_eret2_epc", epc,       32'h0);
    check("t3_eret2_bsy", 32'(busy), 32'h0);
    tick();
    check("t3_idle", 32'(int_req), 32'h0);

    // 4: masking withdraws the request but keeps pending.
    pulse(2);
    tick(3);
    check("t4_req", 32'(int_req), 32'h1);
    mask = 3'b100;
    tick();
    check("t4_masked", 32'(int_req), 32'h0);
    tick(2);
    check("t4_masked_hold", 32'(int_req), 32'h0);
    mask = 3'b000;
    tick();
    check("t4_rereq",      32'(int_req),  32'h1);
    check("t4_rereq_code", 32'(int_code), 32'h2);
    do_take(32'h50);
    check("t4_busy", 32'(busy), 32'h4);
    do_eret();
    check("t4_eret_busy", 32'(busy), 32'h0);
    take = 1'b1;
    tick();
    take = 1'b0;
    check("t4_stray_take_busy", 32'(busy),    32'h0);
    check("t4_stray_take_epc",  epc,          32'h0);
    check("t4_stray_take_req",  32'(int_req), 32'h0);

    // take and eret in the same cycle replace the top entry.
    pulse(1);
    tick(3);
    check("tx_ch1_req", 32'(int_req), 32'h1);
    do_take(32'h60);
    check("tx_ch1_epc", epc, 32'h60);
    tick();
    pulse(2);
    tick(3);
    check("tx_ch2_code", 32'(int_code), 32'h2);
    cur_pc = 32'h70;
    take   = 1'b1;
    eret   = 1'b1;
    tick();
    take   = 1'b0;
    eret   = 1'b0;
    check("tx_swap_busy", 32'(busy), 32'h4);
    check("tx_swap_epc",  epc,       32'h70);
    tick();
    do_eret();
    check("tx_drain_busy", 32'(busy),     32'h0);
    check("tx_drain_epc",  epc,           32'h0);
    check("tx_drain_nerr", 32'(nest_err), 32'h0);

    // 5: eret on an empty stack is sticky-flagged.
    do_eret();
    check("t5_nerr", 32'(nest_err), 32'h1);
    check("t5_busy", 32'(busy),     32'h0);
    check("t5_epc",  epc,           32'h0);
    tick(2);
    check("t5_nerr_sticky", 32'(nest_err), 32'h1);
    pulse(1);
    tick(3);
    check("t5_req", 32'(int_req), 32'h1);
`endif

    // Asynchronous reset mid-request, between clock edges.
    #2;
    in_RST = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    in_RST = 1'b1;
    tick(5);
    check("post_rst_idle", 32'(int_req), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
